// File: rtl/data_mem_ws.sv
// data_mem_ws: word-organised data memory with a req/ready handshake and a
// fixed number of wait states. Supports byte/halfword/word loads and stores,
// sign or zero extension on sub-word loads, misalignment detection, and a
// registered debug tap of one memory word.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   rst    synchronous active-low reset (clears memory, FSM and outputs)
//   req    access request, held high by the requester until ready
//   WE     1 = store, 0 = load (sampled with req)
//   size   00 byte, 01 halfword, 10 word, 11 reserved (flagged as error)
//   uns    1 = zero-extend, 0 = sign-extend sub-word loads
//   A      byte address; upper bits beyond the memory size are ignored
//   WD     right-aligned store data
//   RD     load result, valid while ready=1, held until the next completion
//   ready  one-cycle completion pulse
//   err    misaligned or reserved-size access, valid while ready=1
//   tst    registered copy of mem[TST_WORD]
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for req; request fields are latched on acceptance
// ST_WAIT | counting wait states on the latched request
// ST_DONE | access performed, ready/RD/err presented for one cycle

module data_mem_ws #(
  parameter int DEPTH    = 64,
  parameter int WAIT     = 1,
  parameter int TST_WORD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        WE,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        ready,
  output logic        err,
  output logic [31:0] tst
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] WAIT_LAST = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW+1:0] a_q, a_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   rd_q, rd_d;
  logic          ready_q, ready_d;
  logic          err_q, err_d;
  logic [31:0]   tst_q, tst_d;
  logic [31:0]   mem_q [DEPTH];

  logic [AW+1:0] acc_a;
  logic          acc_we;
  logic [1:0]    acc_size;
  logic          acc_uns;
  logic          acc_err;
  logic [31:0]   acc_word;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_val;
  logic          wr_en;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;

  // Address bits above the memory size only cause wrap-around.
  logic unused_a;
  assign unused_a = ^A[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wd_d    = wd_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          a_d     = A[AW+1:0];
          we_d    = WE;
          size_d  = size;
          uns_d   = uns;
          wd_d    = WD;
          cnt_d   = '0;
          state_d = (WAIT > 0) ? ST_WAIT : ST_DONE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == WAIT_LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // With zero wait states the access is evaluated straight from the inputs
  // on the acceptance edge, so the result registers are valid in ST_DONE.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_a    = A[AW+1:0];
      acc_we   = WE;
      acc_size = size;
      acc_uns  = uns;
    end else begin
      acc_a    = a_q;
      acc_we   = we_q;
      acc_size = size_q;
      acc_uns  = uns_q;
    end
    acc_err  = (acc_size == 2'b11) ||
               (acc_size == 2'b01 && acc_a[0]) ||
               (acc_size == 2'b10 && acc_a[1:0] != 2'b00);
    acc_word = mem_q[acc_a[AW+1:2]];
    case (acc_a[1:0])
      2'd0:    ld_byte = acc_word[7:0];
      2'd1:    ld_byte = acc_word[15:8];
      2'd2:    ld_byte = acc_word[23:16];
      default: ld_byte = acc_word[31:24];
    endcase
    ld_half = acc_a[1] ? acc_word[31:16] : acc_word[15:0];
    case (acc_size)
      2'b00:   ld_val = {{24{ld_byte[7] & ~acc_uns}}, ld_byte};
      2'b01:   ld_val = {{16{ld_half[15] & ~acc_uns}}, ld_half};
      default: ld_val = acc_word;
    endcase

    ready_d = (state_d == ST_DONE);
    rd_d    = rd_q;
    err_d   = 1'b0;
    if (state_d == ST_DONE) begin
      err_d = acc_err;
      rd_d  = (acc_err || acc_we) ? 32'h0 : ld_val;
    end
    tst_d = mem_q[TST_WORD];
  end

  // The store commits on the edge that leaves ST_DONE, using latched fields.
  always_comb begin
    wr_en = (state_q == ST_DONE) && we_q && !err_q;
    case (size_q)
      2'b00: begin
        wr_be   = 4'b0001 << a_q[1:0];
        wr_data = {4{wd_q[7:0]}};
      end
      2'b01: begin
        wr_be   = a_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wd_q[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = wd_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wd_q    <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      tst_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wd_q    <= wd_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      tst_q   <= tst_d;
      if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be[b]) mem_q[a_q[AW+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  assign RD    = rd_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign tst   = tst_q;

endmodule
